// File: rtl/alu_issue_pkg.sv
// Shared definitions for the alu_issue block.
//   - ALU operation encodings (aluc) understood by alu_issue_alu
//   - MIPS opcode / funct constants decoded by alu_issue
//   - issue FSM state type
//   - bit positions inside the 4-bit {zero, carry, negative, overflow} flag vector
package alu_issue_pkg;

   localparam logic [3:0] ALUC_ADDU = 4'b0000;
   localparam logic [3:0] ALUC_SUBU = 4'b0001;
   localparam logic [3:0] ALUC_ADD  = 4'b0010;
   localparam logic [3:0] ALUC_SUB  = 4'b0011;
   localparam logic [3:0] ALUC_AND  = 4'b0100;
   localparam logic [3:0] ALUC_OR   = 4'b0101;
   localparam logic [3:0] ALUC_XOR  = 4'b0110;
   localparam logic [3:0] ALUC_NOR  = 4'b0111;
   localparam logic [3:0] ALUC_LUI  = 4'b1000;
   localparam logic [3:0] ALUC_SLTU = 4'b1010;
   localparam logic [3:0] ALUC_SLT  = 4'b1011;
   localparam logic [3:0] ALUC_SRA  = 4'b1100;
   localparam logic [3:0] ALUC_SRL  = 4'b1101;
   localparam logic [3:0] ALUC_SLL  = 4'b1110;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int FLAG_ZERO  = 3;
   localparam int FLAG_CARRY = 2;
   localparam int FLAG_NEG   = 1;
   localparam int FLAG_OVF   = 0;

   // Decoded view of one instruction: ALU controls plus which ALU flags survive.
   typedef struct packed {
      logic [3:0]  aluc;
      logic [31:0] a;
      logic [31:0] b;
      logic        legal;
      logic        keep_carry;
      logic        keep_ovf;
   } decode_t;

   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/alu_issue_alu.sv
// Combinational MIPS-style ALU.
//   a, b    : operands (shifts use a[4:0] as the amount and shift b)
//   aluc    : operation select (ALUC_* encodings)
//   result  : 32-bit result
//   flags   : {zero, carry, negative, overflow}; carry is the unsigned carry-out
//             for adds, the borrow for subtract/set-less-than-unsigned, and the
//             last bit shifted out for shifts (0 for a shift of zero)
module alu_issue_alu
   import alu_issue_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  aluc,
   output logic [31:0] result,
   output logic [3:0]  flags
);

   logic [4:0]         sh;
   logic [32:0]        sum;
   logic [32:0]        diff;
   logic [32:0]        shl;
   logic [32:0]        shr;
   logic signed [32:0] sra;
   logic               carry;
   logic               ovf;

   assign sh   = a[4:0];
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};   // diff[32] is the borrow
   // One guard bit on the outgoing side catches the last bit shifted out.
   assign shl  = {1'b0, b} << sh;
   assign shr  = {b, 1'b0} >> sh;
   assign sra  = $signed({b, 1'b0}) >>> sh;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (aluc)
         ALUC_ADDU: begin result = sum[31:0];  carry = sum[32]; end
         ALUC_ADD: begin
            result = sum[31:0];
            carry  = sum[32];
            ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         ALUC_SUBU: begin result = diff[31:0]; carry = diff[32]; end
         ALUC_SUB: begin
            result = diff[31:0];
            carry  = diff[32];
            ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         ALUC_AND:  result = a & b;
         ALUC_OR:   result = a | b;
         ALUC_XOR:  result = a ^ b;
         ALUC_NOR:  result = ~(a | b);
         ALUC_LUI:  result = {b[15:0], 16'h0000};
         ALUC_SLT:  result = {31'b0, $signed(a) < $signed(b)};
         ALUC_SLTU: begin result = {31'b0, diff[32]}; carry = diff[32]; end
         ALUC_SRA:  begin result = sra[32:1]; carry = sra[0]; end
         ALUC_SRL:  begin result = shr[32:1]; carry = shr[0]; end
         ALUC_SLL:  begin result = shl[31:0]; carry = shl[32]; end
         default: ;
      endcase
      flags[FLAG_ZERO]  = (result == 32'd0);
      flags[FLAG_CARRY] = carry;
      flags[FLAG_NEG]   = result[31];
      flags[FLAG_OVF]   = ovf;
   end

endmodule

// File: rtl/alu_issue.sv
// Single-issue ALU stage: accepts one MIPS ALU instruction with its rs/rt
// values, decodes it, runs it through alu_issue_alu and returns the result.
// Sequence per instruction: IDLE (accept) -> EXEC (decode + ALU) -> RESP (hold
// until resp_ready).
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake; req_ready only in IDLE
//   req_instr/rs/rt       : instruction word and register operands
//   resp_valid/resp_ready : response handshake; resp_valid only in RESP
//   resp_result/flags     : ALU result and masked {zero, carry, negative, overflow}
//   resp_exc              : trapping signed overflow (ADD/ADDI/SUB, if TRAP_EN)
//   resp_illegal          : instruction not handled by this block
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter logic TRAP_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_instr,
   input  logic [31:0] req_rs,
   input  logic [31:0] req_rt,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic [3:0]  resp_flags,
   output logic        resp_exc,
   output logic        resp_illegal
);

   state_t      state_reg, state_next;
   logic [31:0] instr_reg, rs_reg, rt_reg;
   logic [31:0] result_reg;
   logic [3:0]  flags_reg;
   logic        exc_reg, illegal_reg;

   logic        accept, resp_done;
   decode_t     dec;
   logic [31:0] alu_result;
   logic [3:0]  alu_flags, keep_mask, flags_masked;
   logic [5:0]  opcode, funct;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic        instr_fields_unused;

   assign accept    = req_valid & req_ready;
   assign resp_done = resp_valid & resp_ready;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (req_valid) state_next = ST_EXEC;
         ST_EXEC: state_next = ST_RESP;
         ST_RESP: if (resp_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state_reg)
         ST_IDLE: req_ready  = 1'b1;
         ST_RESP: resp_valid = 1'b1;
         default: ;
      endcase
   end

   // ---------------- decode ----------------
   assign opcode = instr_reg[31:26];
   assign funct  = instr_reg[5:0];
   assign shamt  = instr_reg[10:6];
   assign imm    = instr_reg[15:0];
   // Register-number fields are meaningless here: operand values arrive on req_rs/req_rt.
   assign instr_fields_unused = ^instr_reg[25:16];

   always_comb begin
      dec   = '0;
      dec.a = rs_reg;
      dec.b = rt_reg;
      case (opcode)
         OP_RTYPE: begin
            dec.legal = 1'b1;
            case (funct)
               F_ADD:  begin dec.aluc = ALUC_ADD;  dec.keep_ovf   = 1'b1; end
               F_ADDU: begin dec.aluc = ALUC_ADDU; dec.keep_carry = 1'b1; end
               F_SUB:  begin dec.aluc = ALUC_SUB;  dec.keep_ovf   = 1'b1; end
               F_SUBU: begin dec.aluc = ALUC_SUBU; dec.keep_carry = 1'b1; end
               F_AND:  dec.aluc = ALUC_AND;
               F_OR:   dec.aluc = ALUC_OR;
               F_XOR:  dec.aluc = ALUC_XOR;
               F_NOR:  dec.aluc = ALUC_NOR;
               F_SLT:  dec.aluc = ALUC_SLT;
               F_SLTU: begin dec.aluc = ALUC_SLTU; dec.keep_carry = 1'b1; end
               F_SLL:  begin dec.aluc = ALUC_SLL; dec.a = {27'b0, shamt};       dec.keep_carry = 1'b1; end
               F_SRL:  begin dec.aluc = ALUC_SRL; dec.a = {27'b0, shamt};       dec.keep_carry = 1'b1; end
               F_SRA:  begin dec.aluc = ALUC_SRA; dec.a = {27'b0, shamt};       dec.keep_carry = 1'b1; end
               F_SLLV: begin dec.aluc = ALUC_SLL; dec.a = {27'b0, rs_reg[4:0]}; dec.keep_carry = 1'b1; end
               F_SRLV: begin dec.aluc = ALUC_SRL; dec.a = {27'b0, rs_reg[4:0]}; dec.keep_carry = 1'b1; end
               F_SRAV: begin dec.aluc = ALUC_SRA; dec.a = {27'b0, rs_reg[4:0]}; dec.keep_carry = 1'b1; end
               default: dec.legal = 1'b0;
            endcase
         end
         OP_ADDI:  begin dec.legal = 1'b1; dec.aluc = ALUC_ADD;  dec.b = sext16(imm); dec.keep_ovf   = 1'b1; end
         OP_ADDIU: begin dec.legal = 1'b1; dec.aluc = ALUC_ADDU; dec.b = sext16(imm); dec.keep_carry = 1'b1; end
         OP_SLTI:  begin dec.legal = 1'b1; dec.aluc = ALUC_SLT;  dec.b = sext16(imm); end
         OP_SLTIU: begin dec.legal = 1'b1; dec.aluc = ALUC_SLTU; dec.b = sext16(imm); dec.keep_carry = 1'b1; end
         OP_ANDI:  begin dec.legal = 1'b1; dec.aluc = ALUC_AND;  dec.b = {16'h0000, imm}; end
         OP_ORI:   begin dec.legal = 1'b1; dec.aluc = ALUC_OR;   dec.b = {16'h0000, imm}; end
         OP_XORI:  begin dec.legal = 1'b1; dec.aluc = ALUC_XOR;  dec.b = {16'h0000, imm}; end
         OP_LUI:   begin dec.legal = 1'b1; dec.aluc = ALUC_LUI;  dec.b = {16'h0000, imm}; end
         default: ;
      endcase
   end

   alu_issue_alu u_alu (
      .a      (dec.a),
      .b      (dec.b),
      .aluc   (dec.aluc),
      .result (alu_result),
      .flags  (alu_flags)
   );

   // zero/negative always pass; carry/overflow only for the ops that define them.
   assign keep_mask[FLAG_ZERO]  = 1'b1;
   assign keep_mask[FLAG_CARRY] = dec.keep_carry;
   assign keep_mask[FLAG_NEG]   = 1'b1;
   assign keep_mask[FLAG_OVF]   = dec.keep_ovf;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_flag_mask
         assign flags_masked[gi] = alu_flags[gi] & keep_mask[gi];
      end
   endgenerate

   // ---------------- operand and response registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_reg <= '0;
         rs_reg    <= '0;
         rt_reg    <= '0;
      end else if (accept) begin
         instr_reg <= req_instr;
         rs_reg    <= req_rs;
         rt_reg    <= req_rt;
      end
   end

   // Response registers are fully rewritten every EXEC, so nothing from an
   // earlier instruction can survive into the next response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_reg  <= '0;
         flags_reg   <= '0;
         exc_reg     <= 1'b0;
         illegal_reg <= 1'b0;
      end else if (state_reg == ST_EXEC) begin
         result_reg  <= dec.legal ? alu_result   : 32'd0;
         flags_reg   <= dec.legal ? flags_masked : 4'd0;
         exc_reg     <= dec.legal & TRAP_EN & flags_masked[FLAG_OVF];
         illegal_reg <= ~dec.legal;
      end else if (resp_done) begin
         result_reg  <= '0;
         flags_reg   <= '0;
         exc_reg     <= 1'b0;
         illegal_reg <= 1'b0;
      end
   end

   assign resp_result  = result_reg;
   assign resp_flags   = flags_reg;
   assign resp_exc     = exc_reg;
   assign resp_illegal = illegal_reg;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_instr, req_rs, req_rt;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic [3:0]  resp_flags;
   logic        resp_exc;
   logic        resp_illegal;

   alu_issue #(.TRAP_EN(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_instr    (req_instr),
      .req_rs       (req_rs),
      .req_rt       (req_rt),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_result  (resp_result),
      .resp_flags   (resp_flags),
      .resp_exc     (resp_exc),
      .resp_illegal (resp_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] result;
      logic [3:0]  flags;     // {zero, carry, negative, overflow}
      logic        exc;
      logic        illegal;
      int          acc_cyc;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   ready_mode = 2;   // 0 random, 1 held low, 2 held high

   logic [5:0] rfuncts [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
   logic [5:0] bad_functs [4] = '{6'h01, 6'h05, 6'h08, 6'h3F};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] r, input logic [3:0] f, input logic e, input logic il);
      exp_t x;
      x.result = r; x.flags = f; x.exc = e; x.illegal = il; x.acc_cyc = 0; x.tag = "";
      return x;
   endfunction

   // Reference model: instruction semantics with plain integer arithmetic.
   function automatic exp_t model(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
      logic [5:0]  op, fn;
      logic [31:0] x, y, r, simm, zimm;
      logic [63:0] full;
      longint      sx, sy, s;
      logic        c, v;
      int          n;
      string       opn;
      op = instr[31:26]; fn = instr[5:0];
      simm = {{16{instr[15]}}, instr[15:0]};
      zimm = {16'h0000, instr[15:0]};
      x = rs; y = rt; opn = "ILL";
      case (op)
         6'h00: case (fn)
            6'h20: opn = "ADD";  6'h21: opn = "ADDU"; 6'h22: opn = "SUB"; 6'h23: opn = "SUBU";
            6'h24: opn = "AND";  6'h25: opn = "OR";   6'h26: opn = "XOR"; 6'h27: opn = "NOR";
            6'h2A: opn = "SLT";  6'h2B: opn = "SLTU";
            6'h00: begin opn = "SLL"; x = 32'(instr[10:6]); end
            6'h02: begin opn = "SRL"; x = 32'(instr[10:6]); end
            6'h03: begin opn = "SRA"; x = 32'(instr[10:6]); end
            6'h04: begin opn = "SLL"; x = 32'(rs[4:0]); end
            6'h06: begin opn = "SRL"; x = 32'(rs[4:0]); end
            6'h07: begin opn = "SRA"; x = 32'(rs[4:0]); end
            default: ;
         endcase
         6'h08: begin opn = "ADD";  y = simm; end
         6'h09: begin opn = "ADDU"; y = simm; end
         6'h0A: begin opn = "SLT";  y = simm; end
         6'h0B: begin opn = "SLTU"; y = simm; end
         6'h0C: begin opn = "AND";  y = zimm; end
         6'h0D: begin opn = "OR";   y = zimm; end
         6'h0E: begin opn = "XOR";  y = zimm; end
         6'h0F: begin opn = "LUI";  y = zimm; end
         default: ;
      endcase
      if (opn == "ILL") return mk(32'd0, 4'd0, 1'b0, 1'b1);
      sx = longint'($signed(x)); sy = longint'($signed(y));
      r = 0; c = 0; v = 0; n = int'(x);
      case (opn)
         "ADD", "ADDU": begin
            full = 64'(x) + 64'(y); r = full[31:0]; c = full[32];
            s = sx + sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         "SUB", "SUBU": begin
            r = x - y; c = (x < y);
            s = sx - sy; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         "AND":  r = x & y;
         "OR":   r = x | y;
         "XOR":  r = x ^ y;
         "NOR":  r = ~(x | y);
         "SLT":  r = (sx < sy) ? 32'd1 : 32'd0;
         "SLTU": begin r = (x < y) ? 32'd1 : 32'd0; c = (x < y); end
         "LUI":  r = y << 16;
         "SLL":  begin r = y << n; full = 64'(y) << n; c = (n != 0) && full[32]; end
         "SRL":  begin r = y >> n; c = (n != 0) && ((y >> (n - 1)) & 32'd1) != 0; end
         "SRA":  begin r = $signed(y) >>> n; c = (n != 0) && ((y >> (n - 1)) & 32'd1) != 0; end
         default: ;
      endcase
      if (!(opn inside {"ADDU", "SUBU", "SLTU", "SLL", "SRL", "SRA"})) c = 0;
      if (!(opn inside {"ADD", "SUB"})) v = 0;
      return mk(r, {r == 32'd0, c, r[31], v}, v, 1'b0);
   endfunction

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 7))
         0: return 32'h7FFFFFFF;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'h00000000;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k <= 4) begin
         w[31:26] = 6'h00; w[5:0] = rfuncts[$urandom_range(0, 15)];
      end else if (k <= 7) begin
         w[31:26] = 6'h08 + 6'($urandom_range(0, 7));
      end else if (k == 8) begin
         w[31:26] = 6'h00; w[5:0] = bad_functs[$urandom_range(0, 3)];
      end else begin
         w[31:26] = 6'($urandom_range(16, 63));
      end
      return w;
   endfunction

   // Issue one request; returns once the accept edge has passed (DUT then in EXEC).
   task automatic issue(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                        input bit use_exp, input exp_t e_in, input string tag, output int waited);
      exp_t e;
      e = use_exp ? e_in : model(instr, rs, rt);
      e.tag = tag;
      req_valid = 1'b1; req_instr = instr; req_rs = rs; req_rt = rt;
      waited = 0;
      while (1) begin
         @(negedge clk);
         if (req_ready) break;
         waited++;
         if (waited > 200) begin
            errors++; checks++;
            $display("FAIL accept_timeout_%s: req_ready=0 after %0d cycles, required 1", tag, waited);
            break;
         end
      end
      if (req_ready) begin
         e.acc_cyc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      // Garbage while the instruction is in flight; the DUT must ignore it.
      req_valid = 1'b0; req_instr = $urandom; req_rs = $urandom; req_rt = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || !req_ready) && n < 500) begin
         @(negedge clk); n++;
      end
      if (n >= 500) begin
         errors++; checks++;
         $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      end
      @(posedge clk); #1;
   endtask

   initial forever begin
      @(posedge clk); cyc++;
   end

   initial begin
      resp_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       resp_ready = 1'($urandom_range(0, 1));
            1:       resp_ready = 1'b0;
            default: resp_ready = 1'b1;
         endcase
      end
   end

   // Monitor: pops the scoreboard when a new response appears, checks hold otherwise.
   initial begin
      exp_t        cur;
      logic        seen;
      logic [31:0] h_res;
      logic [3:0]  h_flg;
      logic        h_exc, h_ill;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            chk("req_ready_during_resp", 32'(req_ready), 32'd0);
            if (!seen) begin
               if (sb.size() == 0) begin
                  errors++; checks++;
                  $display("FAIL unexpected_resp: got response result=%h, required no response", resp_result);
               end else begin
                  cur = sb.pop_front();
                  $display("txn %s: result=%h flags=%b exc=%b illegal=%b", cur.tag,
                           resp_result, resp_flags, resp_exc, resp_illegal);
                  chk({cur.tag, "_result"},  resp_result,          cur.result);
                  chk({cur.tag, "_flags"},   32'(resp_flags),      32'(cur.flags));
                  chk({cur.tag, "_exc"},     32'(resp_exc),        32'(cur.exc));
                  chk({cur.tag, "_illegal"}, 32'(resp_illegal),    32'(cur.illegal));
                  chk({cur.tag, "_latency"}, 32'(cyc),             32'(cur.acc_cyc + 1));
               end
               seen = 1'b1;
               h_res = resp_result; h_flg = resp_flags; h_exc = resp_exc; h_ill = resp_illegal;
            end else begin
               chk("hold_result",  resp_result,       h_res);
               chk("hold_flags",   32'(resp_flags),   32'(h_flg));
               chk("hold_exc",     32'(resp_exc),     32'(h_exc));
               chk("hold_illegal", 32'(resp_illegal), 32'(h_ill));
            end
            if (resp_ready === 1'b1) seen = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int w, w2, n;
      rst = 1'b1; req_valid = 1'b0; req_instr = '0; req_rs = '0; req_rt = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready",    32'(req_ready),    32'd1);
      chk("reset_resp_valid",   32'(resp_valid),   32'd0);
      chk("reset_resp_result",  resp_result,       32'd0);
      chk("reset_resp_flags",   32'(resp_flags),   32'd0);
      chk("reset_resp_exc",     32'(resp_exc),     32'd0);
      chk("reset_resp_illegal", 32'(resp_illegal), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed cases with hand-derived expectations.
      ready_mode = 2;
      issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h7FFFFFFF, 32'h1, 1,
            mk(32'h80000000, 4'b0011, 1'b1, 1'b0), "add_ovf", w);
      chk("first_accept_after_reset", 32'(w), 32'd0);
      drain();
      issue({6'h09, 5'd1, 5'd2, 16'hFFFF}, 32'h1, 32'h5555, 1,
            mk(32'h0, 4'b1100, 1'b0, 1'b0), "addiu_carry", w);
      drain();
      issue({6'h0F, 5'd0, 5'd2, 16'h1234}, 32'hCAFEF00D, 32'h0, 1,
            mk(32'h12340000, 4'b0000, 1'b0, 1'b0), "lui", w);
      drain();
      issue({6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h03}, 32'hDEADBEEF, 32'h80000000, 1,
            mk(32'hF8000000, 4'b0010, 1'b0, 1'b0), "sra", w);
      drain();
      issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h07}, 32'h24, 32'h80000000, 1,
            mk(32'hF8000000, 4'b0010, 1'b0, 1'b0), "srav", w);
      drain();
      issue({6'h3F, 26'h2ABCDEF}, 32'h12345678, 32'h9ABCDEF0, 1,
            mk(32'h0, 4'b0000, 1'b0, 1'b1), "illegal_op", w);
      drain();

      // Back-pressure: response held 5 cycles while a second request waits.
      ready_mode = 1;
      issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'd5, 32'd7, 0, mk(0, 0, 0, 0), "stall_first", w);
      fork
         issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h23}, 32'd3, 32'd9, 0, mk(0, 0, 0, 0), "stall_second", w2);
         begin
            n = 0;
            while (resp_valid !== 1'b1 && n < 10) begin
               @(negedge clk); n++;
            end
            repeat (5) begin
               @(negedge clk);
               chk("stall_req_ready",  32'(req_ready),  32'd0);
               chk("stall_resp_valid", 32'(resp_valid), 32'd1);
            end
            ready_mode = 2;
         end
      join
      drain();

      // Reset pulse while an instruction sits in EXEC.
      issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}, 32'hF0F0F0F0, 32'h0F0F0F0F, 0, mk(0, 0, 0, 0), "pre_reset", w);
      sb.delete();
      rst = 1'b1;
      #1;
      chk("rst_exec_req_ready",    32'(req_ready),    32'd1);
      chk("rst_exec_resp_valid",   32'(resp_valid),   32'd0);
      chk("rst_exec_resp_result",  resp_result,       32'd0);
      chk("rst_exec_resp_flags",   32'(resp_flags),   32'd0);
      chk("rst_exec_resp_exc",     32'(resp_exc),     32'd0);
      chk("rst_exec_resp_illegal", 32'(resp_illegal), 32'd0);
      #1;
      rst = 1'b0;
      issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h22}, 32'h80000000, 32'h1, 0, mk(0, 0, 0, 0), "post_reset", w);
      chk("accept_after_rst_pulse", 32'(w), 32'd0);
      drain();

      // Randomized traffic with random response back-pressure.
      ready_mode = 0;
      for (int i = 0; i < 150; i++) begin
         issue(rand_instr(), rand_val(), rand_val(), 0, mk(0, 0, 0, 0), $sformatf("rnd%0d", i), w);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      ready_mode = 2;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one parameter: TRAP_EN, default 1, meaning resp_exc is asserted on signed-add/sub overflow (0 disables it).
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept
- req_instr  in  32  MIPS instruction word
- req_rs  in  32  rs register value
- req_rt  in  32  rt register value
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts
- resp_result  out  32  ALU result
- resp_flags  out  4  {zero, carry, negative, overflow}
- resp_exc  out  1  trapping overflow
- resp_illegal  out  1  unsupported instruction
REQ-003 The clocking SHALL be one clock (clk); reset (rst) SHALL be asynchronous and active-high.

Function
REQ-004 The block SHALL implement FSM states IDLE, EXEC and RESP: IDLE->EXEC on req_valid&req_ready; EXEC->RESP unconditionally; RESP->IDLE on resp_ready.
REQ-005 req_ready SHALL be 1 only in IDLE.
REQ-006 instr/rs/rt SHALL be registered at the accept edge; inputs SHALL be ignored outside IDLE.
REQ-007 In EXEC, decoded aluc/a/b SHALL drive the alu instance, and result/flags SHALL be captured into response registers at the EXEC->RESP edge.
REQ-008 resp_valid SHALL rise exactly 2 clk edges after the accept edge.
REQ-009 All resp_* outputs SHALL be 1 only in RESP (resp_valid) and held stable until the resp_valid&resp_ready edge.
REQ-010 Throughput SHALL be at most one instruction per 3 cycles; there is no back-to-back accept from RESP.
REQ-011 R-type decode (opcode 0) SHALL map funct to aluc: 20 ADD=0010, 21 ADDU=0000, 22 SUB=0011, 23 SUBU=0001, 24 AND=0100, 25 OR=0101, 26 XOR=0110, 27 NOR=0111, 2A SLT=1011, 2B SLTU=1010, 00 SLL=1110, 02 SRL=1101, 03 SRA=1100, 04 SLLV=1110, 06 SRLV=1101, 07 SRAV=1100 (funct in hex).
REQ-012 I-type decode SHALL map opcode to aluc: 08 ADDI=0010, 09 ADDIU=0000, 0A SLTI=1011, 0B SLTIU=1010, all with sign-extended imm; 0C ANDI=0100, 0D ORI=0101, 0E XORI=0110, all with zero-extended imm; 0F LUI=1000 (opcode in hex).
REQ-013 Operands SHALL be: default a=rs, b=rt; I-type b=extended imm; SLL/SRL/SRA a={27'b0,shamt}, b=rt; SLLV/SRLV/SRAV a={27'b0,rs[4:0]}, b=rt.
REQ-014 Any other opcode/funct SHALL still traverse EXEC, and the response SHALL be result=0, flags=0, illegal=1, exc=0.
REQ-015 Flag masking: carry SHALL be kept only for ADDU/ADDIU/SUBU/SLTU/SLTIU/shifts, and forced 0 otherwise.
REQ-016 overflow SHALL be kept only for ADD/ADDI/SUB, and forced 0 otherwise.
REQ-017 zero and negative SHALL be passed from the ALU.
REQ-018 resp_exc SHALL equal TRAP_EN & overflow for ADD/ADDI/SUB; the result is still reported.
REQ-019 No ALU flag value from a previous operation SHALL leak into a response.

Reset
REQ-020 rst SHALL force state IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_flags=0, resp_exc=0, resp_illegal=0, and clear all operand registers immediately, regardless of clk.
REQ-021 rst asserted in EXEC or RESP SHALL discard the in-flight instruction with no response.
REQ-022 The first accept after reset release SHALL be allowed on the first clk edge.

Structure
REQ-023 The shared package SHALL hold the aluc encodings, the opcode/funct constants, the FSM state enum and the flag bit indices.
REQ-024 The block SHALL contain exactly one sub-module: the existing alu, instantiated once; decode SHALL be in-module combinational logic.

Verification
REQ-025 ADD, rs=0x7FFFFFFF, rt=1 -> result 0x80000000, overflow=1, negative=1, exc=1, resp_valid at accept+2.
REQ-026 ADDIU, rs=1, imm=0xFFFF -> result 0, zero=1, carry=1, overflow=0, exc=0.
REQ-027 LUI, imm=0x1234 -> result 0x12340000, flags=0.
REQ-028 SRA, shamt=4, rt=0x80000000 -> 0xF8000000, negative=1; SRAV with rs=0x24 -> shift of 4, same result.
REQ-029 resp_ready held 0 for 5 cycles with a second req_valid pending -> response stable, req_ready=0, second request accepted only in IDLE after the handshake.
REQ-030 opcode 0x3F -> illegal=1, result=0.
REQ-031 rst pulsed during EXEC -> all outputs reset, no response, next request served normally.
